// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cp0_pkg
// Purpose  : Register numbers, field positions, ExcCodes and write masks
//            shared by the coprocessor-0 block and its timer.
// Revision : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int ST_IM_LO   = 8;
    localparam int ST_IM_HI   = 15;
    localparam int ST_BEV     = 22;
    localparam int CA_EXC_LO  = 2;
    localparam int CA_EXC_HI  = 6;
    localparam int CA_IP_LO   = 8;
    localparam int CA_IP_HI   = 15;
    localparam int CA_TI      = 30;
    localparam int CA_BD      = 31;

    localparam int EXB_ADES   = 0;
    localparam int EXB_ADEL_D = 1;
    localparam int EXB_SYS    = 2;
    localparam int EXB_BP     = 3;
    localparam int EXB_OV     = 4;
    localparam int EXB_RI     = 5;
    localparam int EXB_ADEL_F = 6;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_EXC  = 2'd1,
        EV_ERET = 2'd2
    } cp0_event_e;

    function automatic logic [31:0] merge_masked(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module   : cp0_timer
// Purpose  : Count prescaler, Count/Compare registers and the TI match flag.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int PRESC_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PRESC_W-1:0] C_PRESC_MAX = PRESC_W'(COUNT_DIV - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [31:0]        r_count;
    logic [31:0]        r_compare;
    logic               r_ti;
    logic               w_tick;
    logic [31:0]        w_count_inc;

    assign w_tick      = (r_presc == C_PRESC_MAX);
    assign w_count_inc = r_count + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc   <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            if (count_we) begin
                r_count <= wdata;
                r_presc <= '0;
            end else begin
                r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
                if (w_tick)
                    r_count <= w_count_inc;
            end
            if (compare_we)
                r_compare <= wdata;
            // A Compare write outranks a same-cycle match
            if (compare_we)
                r_ti <= 1'b0;
            else if (!count_we && w_tick && (w_count_inc == r_compare))
                r_ti <= 1'b1;
        end
    end

    assign count   = r_count;
    assign compare = r_compare;
    assign ti      = r_ti;

endmodule
`default_nettype wire

// File: rtl/cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cp0_ctrl
// Purpose  : Coprocessor-0 registers with commit-stage exception, interrupt
//            and ERET arbitration driving a one-cycle flush/redirect.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          HW_INT_NUM = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            raddr_i,
    output logic [31:0]           rdata_o,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  commit_valid_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_delayslot_i,
    input  logic [6:0]            exc_i,
    input  logic [31:0]           badvaddr_i,
    input  logic                  eret_i,
    input  logic [HW_INT_NUM-1:0] int_i,
    output logic                  flush_o,
    output logic [31:0]           flush_pc_o,
    output logic                  timer_int_o
);

    logic [31:0]           r_badvaddr;
    logic [31:0]           r_epc;
    logic [7:0]            r_im;
    logic                  r_exl;
    logic                  r_ie;
    logic [1:0]            r_ip_sw;
    logic [HW_INT_NUM-1:0] r_ip_hw;
    logic                  r_bd;
    logic [4:0]            r_exccode;
    logic                  r_flush;
    logic [31:0]           r_flush_pc;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [7:0]  w_ip;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic        w_int_pending;
    cp0_event_e  w_event;
    logic [4:0]  w_code;
    logic        w_bva_we;
    logic [31:0] w_bva_val;
    logic        w_wr_en;

    always_comb begin
        w_ip                  = '0;
        w_ip[1:0]             = r_ip_sw;
        w_ip[HW_INT_NUM+1:2]  = r_ip_hw;
        w_ip[7]               = w_ip[7] | w_ti;
    end

    assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause  = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};

    assign w_int_pending = r_ie && !r_exl && |(w_ip & r_im);

    always_comb begin
        w_event   = EV_NONE;
        w_code    = EXC_INT;
        w_bva_we  = 1'b0;
        w_bva_val = badvaddr_i;
        if (commit_valid_i) begin
            w_event = EV_EXC;
            if (w_int_pending)            w_code = EXC_INT;
            else if (exc_i[EXB_ADEL_F]) begin
                w_code    = EXC_ADEL;
                w_bva_we  = 1'b1;
                w_bva_val = pc_i;
            end
            else if (exc_i[EXB_RI])       w_code = EXC_RI;
            else if (exc_i[EXB_OV])       w_code = EXC_OV;
            else if (exc_i[EXB_BP])       w_code = EXC_BP;
            else if (exc_i[EXB_SYS])      w_code = EXC_SYS;
            else if (exc_i[EXB_ADEL_D]) begin
                w_code   = EXC_ADEL;
                w_bva_we = 1'b1;
            end
            else if (exc_i[EXB_ADES]) begin
                w_code   = EXC_ADES;
                w_bva_we = 1'b1;
            end
            else if (eret_i)              w_event = EV_ERET;
            else                          w_event = EV_NONE;
        end
    end

    assign w_wr_en = we_i && (w_event == EV_NONE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (w_wr_en && (waddr_i == REG_COUNT)),
        .compare_we (w_wr_en && (waddr_i == REG_COMPARE)),
        .wdata      (wdata_i),
        .count      (w_count),
        .compare    (w_compare),
        .ti         (w_ti)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_badvaddr <= '0;
            r_epc      <= '0;
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_ip_sw    <= '0;
            r_ip_hw    <= '0;
            r_bd       <= 1'b0;
            r_exccode  <= '0;
            r_flush    <= 1'b0;
            r_flush_pc <= '0;
        end else begin
            r_ip_hw <= int_i;
            r_flush <= (w_event != EV_NONE);
            case (w_event)
                EV_EXC: begin
                    // Nested exceptions keep the original return point
                    if (!r_exl) begin
                        r_epc <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
                        r_bd  <= in_delayslot_i;
                    end
                    r_exl      <= 1'b1;
                    r_exccode  <= w_code;
                    r_flush_pc <= EXC_VECTOR;
                    if (w_bva_we)
                        r_badvaddr <= w_bva_val;
                end
                EV_ERET: begin
                    r_exl      <= 1'b0;
                    r_flush_pc <= r_epc;
                end
                default: begin
                    if (w_wr_en) begin
                        case (waddr_i)
                            REG_STATUS: begin
                                r_im  <= wdata_i[ST_IM_HI:ST_IM_LO];
                                r_exl <= wdata_i[ST_EXL];
                                r_ie  <= wdata_i[ST_IE];
                            end
                            REG_CAUSE: r_ip_sw <= wdata_i[CA_IP_LO+1:CA_IP_LO];
                            REG_EPC:   r_epc   <= wdata_i;
                            default:   ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        case (raddr_i)
            REG_BADVADDR: rdata_o = r_badvaddr;
            REG_COUNT:    rdata_o = w_count;
            REG_COMPARE:  rdata_o = w_compare;
            REG_STATUS:   rdata_o = w_status;
            REG_CAUSE:    rdata_o = w_cause;
            REG_EPC:      rdata_o = r_epc;
            default:      rdata_o = '0;
        endcase
        if (we_i && (waddr_i == raddr_i)) begin
            case (raddr_i)
                REG_COUNT, REG_COMPARE, REG_EPC: rdata_o = wdata_i;
                REG_STATUS: rdata_o = merge_masked(w_status, wdata_i, STATUS_WMASK);
                REG_CAUSE:  rdata_o = merge_masked(w_cause, wdata_i, CAUSE_WMASK);
                default:    ;
            endcase
        end
    end

    assign flush_o     = r_flush;
    assign flush_pc_o  = r_flush_pc;
    assign timer_int_o = w_ti;

endmodule
`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_ctrl
// Purpose  : Directed self-checking bench for cp0_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        commit_valid_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [6:0]  exc_i;
    logic [31:0] badvaddr_i;
    logic        eret_i;
    logic [5:0]  int_i;
    logic        flush_o;
    logic [31:0] flush_pc_o;
    logic        timer_int_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0_ctrl #(
        .HW_INT_NUM (6),
        .EXC_VECTOR (32'hbfc0_0380),
        .COUNT_DIV  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .commit_valid_i (commit_valid_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .exc_i          (exc_i),
        .badvaddr_i     (badvaddr_i),
        .eret_i         (eret_i),
        .int_i          (int_i),
        .flush_o        (flush_o),
        .flush_pc_o     (flush_pc_o),
        .timer_int_o    (timer_int_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        raddr_i = addr;
        #1;
        chk(tag, rdata_o, exp);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        we_i    = 1'b1;
        waddr_i = addr;
        wdata_i = data;
        tick();
        we_i    = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic ds, input logic [6:0] exc,
                          input logic [31:0] bva, input logic eret);
        commit_valid_i = 1'b1;
        pc_i           = pc;
        in_delayslot_i = ds;
        exc_i          = exc;
        badvaddr_i     = bva;
        eret_i         = eret;
        tick();
        commit_valid_i = 1'b0;
        exc_i          = '0;
        eret_i         = 1'b0;
        in_delayslot_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; raddr_i = '0; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        commit_valid_i = 1'b0; pc_i = '0; in_delayslot_i = 1'b0; exc_i = '0;
        badvaddr_i = '0; eret_i = 1'b0; int_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state
        chk("rst_flush", {31'b0, flush_o}, 32'd0);
        chk("rst_flush_pc", flush_pc_o, 32'd0);
        chk("rst_ti", {31'b0, timer_int_o}, 32'd0);
        rd(5'd12, 32'h0040_0000, "rst_status");
        rd(5'd13, 32'h0000_0000, "rst_cause");
        rd(5'd9,  32'h0000_0000, "rst_count");

        // Timer interrupt
        wr(5'd9, 32'd0);
        wr(5'd11, 32'd5);
        wr(5'd12, 32'h0000_8001);
        rd(5'd9, 32'd1, "count_1");
        repeat (7) tick();
        rd(5'd9, 32'd4, "count_4");
        chk("ti_before", {31'b0, timer_int_o}, 32'd0);
        tick();
        chk("ti_rise", {31'b0, timer_int_o}, 32'd1);
        rd(5'd13, 32'h4000_8000, "cause_ti");
        commit(32'h8000_0100, 1'b0, 7'b0, 32'd0, 1'b0);
        chk("int_flush", {31'b0, flush_o}, 32'd1);
        chk("int_flush_pc", flush_pc_o, 32'hbfc0_0380);
        rd(5'd13, 32'h4000_8000, "int_cause");
        rd(5'd12, 32'h0040_8003, "int_status");
        rd(5'd14, 32'h8000_0100, "int_epc");
        tick();
        chk("int_flush_drop", {31'b0, flush_o}, 32'd0);
        wr(5'd11, 32'h1000_0000);
        chk("ti_clear", {31'b0, timer_int_o}, 32'd0);
        rd(5'd13, 32'h0000_0000, "cause_ti_clear");

        // RI beats Sys, delay-slot EPC
        wr(5'd12, 32'h0);
        commit(32'h8000_1004, 1'b1, 7'b0100100, 32'd0, 1'b0);
        chk("ri_flush", {31'b0, flush_o}, 32'd1);
        chk("ri_flush_pc", flush_pc_o, 32'hbfc0_0380);
        rd(5'd14, 32'h8000_1000, "ri_epc");
        rd(5'd13, 32'h8000_0028, "ri_cause");
        rd(5'd12, 32'h0040_0002, "ri_status");
        tick();
        chk("ri_flush_drop", {31'b0, flush_o}, 32'd0);

        // AdES then nested Bp
        wr(5'd12, 32'h0);
        commit(32'h8000_2000, 1'b0, 7'b0000001, 32'h8000_0003, 1'b0);
        rd(5'd8,  32'h8000_0003, "ades_bva");
        rd(5'd13, 32'h0000_0014, "ades_cause");
        rd(5'd14, 32'h8000_2000, "ades_epc");
        commit(32'h8000_3000, 1'b1, 7'b0001000, 32'h1111_1111, 1'b0);
        chk("bp_flush", {31'b0, flush_o}, 32'd1);
        rd(5'd14, 32'h8000_2000, "nested_epc");
        rd(5'd13, 32'h0000_0024, "nested_cause");
        rd(5'd8,  32'h8000_0003, "nested_bva");
        tick();

        // ERET with a dropped Status write
        wr(5'd14, 32'hbfc0_1234);
        we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0000_ff01;
        commit(32'h8000_5000, 1'b0, 7'b0, 32'd0, 1'b1);
        we_i = 1'b0;
        chk("eret_flush", {31'b0, flush_o}, 32'd1);
        chk("eret_flush_pc", flush_pc_o, 32'hbfc0_1234);
        rd(5'd12, 32'h0040_0000, "eret_status");

        // Hardware interrupt 0
        wr(5'd12, 32'h0000_ff01);
        int_i = 6'b000001;
        tick();
        rd(5'd13, 32'h0000_0424, "hw_ip2");
        commit(32'h8000_4000, 1'b0, 7'b0, 32'd0, 1'b0);
        int_i = '0;
        chk("hw_flush", {31'b0, flush_o}, 32'd1);
        chk("hw_flush_pc", flush_pc_o, 32'hbfc0_0380);
        rd(5'd13, 32'h0000_0400, "hw_cause");
        rd(5'd14, 32'h8000_4000, "hw_epc");
        tick();
        chk("hw_flush_drop", {31'b0, flush_o}, 32'd0);

        // Cause write bypass
        we_i = 1'b1; waddr_i = 5'd13; wdata_i = 32'hffff_ffff; raddr_i = 5'd13;
        #1;
        chk("cause_bypass", rdata_o, 32'h0000_0300);
        tick();
        we_i = 1'b0;
        rd(5'd13, 32'h0000_0300, "cause_reg");
        rd(5'd10, 32'h0000_0000, "unmapped");

        // Reset during flush
        commit(32'h8000_6000, 1'b0, 7'b0000100, 32'd0, 1'b0);
        chk("sys_flush", {31'b0, flush_o}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_flush", {31'b0, flush_o}, 32'd0);
        rd(5'd12, 32'h0040_0000, "rst_mid_status");
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
